// File: rtl/combo_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : combo_lock_pkg
// Purpose  : State encoding and width helpers shared by the combination-lock
//            checker and its timer.
// Revision : 1.0 - initial release
// ============================================================================
package combo_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_VERDICT = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_timer
// Purpose  : Loadable down-counter that flags the last cycle of a phase.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  // Parks at zero once drained so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  // Expiry at one makes a phase loaded with N last exactly N cycles.
  assign expired = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/combo_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : combo_lock_ctrl
// Purpose  : Digit-sequence checker with failed-attempt lockout and timed relock.
// Revision : 1.0 - initial release
// ============================================================================
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 50000000,
  parameter int LOCKOUT_CYCLES = 500000000,
  parameter int ENTRY_TIMEOUT  = 250000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enter,
  input  logic [DIGIT_W-1:0]              digit,
  input  logic [CODE_LEN*DIGIT_W-1:0]     code,
  input  logic                            lock_cmd,
  output logic                            unlocked,
  output logic                            alarm,
  output logic                            err,
  output logic [$clog2(CODE_LEN+1)-1:0]   entry_count,
  output logic [$clog2(MAX_FAILS+1)-1:0]  fail_count
);

  localparam int c_ecw  = $clog2(CODE_LEN + 1);
  localparam int c_fcw  = $clog2(MAX_FAILS + 1);
  localparam int c_idxw = $clog2(CODE_LEN);
  localparam int c_tw   = cnt_width(max3(UNLOCK_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT));

  localparam logic [c_tw-1:0]  c_t_unlock  = c_tw'(UNLOCK_CYCLES);
  localparam logic [c_tw-1:0]  c_t_lockout = c_tw'(LOCKOUT_CYCLES);
  localparam logic [c_tw-1:0]  c_t_entry   = c_tw'(ENTRY_TIMEOUT);
  localparam logic [c_ecw-1:0] c_last_idx  = c_ecw'(CODE_LEN - 1);
  localparam logic [c_ecw-1:0] c_full      = c_ecw'(CODE_LEN);
  localparam logic [c_fcw-1:0] c_max_fails = c_fcw'(MAX_FAILS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_ecw-1:0]   r_entry_count;
  logic [c_ecw-1:0]   w_entry_count_nxt;
  logic [c_fcw-1:0]   r_fail_count;
  logic [c_fcw-1:0]   w_fail_count_nxt;
  logic               r_mismatch;
  logic               w_mismatch_nxt;
  logic               r_unlocked;
  logic               r_alarm;
  logic               r_err;

  logic               w_tmr_load;
  logic [c_tw-1:0]    w_tmr_val;
  logic               w_tmr_expired;
  logic               w_digit_ok;

  // First keyed digit lives in the most-significant slice of code.
  logic [DIGIT_W-1:0] w_code_digits [CODE_LEN];

  genvar gi;
  generate
    for (gi = 0; gi < CODE_LEN; gi++) begin : g_code_digits
      assign w_code_digits[gi] = code[(CODE_LEN-1-gi)*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  assign w_digit_ok = (digit == w_code_digits[r_entry_count[c_idxw-1:0]]);

  cycle_timer #(
    .WIDTH (c_tw)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .expired  (w_tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_ENTRY;
      r_entry_count <= '0;
      r_fail_count  <= '0;
      r_mismatch    <= 1'b0;
      r_unlocked    <= 1'b0;
      r_alarm       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_entry_count <= w_entry_count_nxt;
      r_fail_count  <= w_fail_count_nxt;
      r_mismatch    <= w_mismatch_nxt;
      r_unlocked    <= (w_state_nxt == ST_OPEN);
      r_alarm       <= (w_state_nxt == ST_LOCKOUT);
      r_err         <= (r_state == ST_VERDICT) && r_mismatch;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_entry_count_nxt = r_entry_count;
    w_fail_count_nxt  = r_fail_count;
    w_mismatch_nxt    = r_mismatch;
    w_tmr_load        = 1'b0;
    w_tmr_val         = c_t_entry;

    case (r_state)
      ST_ENTRY: begin
        // lock_cmd beats a coincident digit; a digit beats the timeout.
        if (lock_cmd) begin
          w_entry_count_nxt = '0;
          w_mismatch_nxt    = 1'b0;
        end else if (enter) begin
          w_mismatch_nxt = r_mismatch | ~w_digit_ok;
          w_tmr_load     = 1'b1;
          w_tmr_val      = c_t_entry;
          if (r_entry_count == c_last_idx) begin
            w_state_nxt       = ST_VERDICT;
            w_entry_count_nxt = c_full;
          end else begin
            w_entry_count_nxt = r_entry_count + c_ecw'(1);
          end
        end else if ((r_entry_count != '0) && w_tmr_expired) begin
          w_entry_count_nxt = '0;
          w_mismatch_nxt    = 1'b0;
        end
      end

      ST_VERDICT: begin
        w_entry_count_nxt = '0;
        w_mismatch_nxt    = 1'b0;
        if (!r_mismatch) begin
          w_state_nxt      = ST_OPEN;
          w_fail_count_nxt = '0;
          w_tmr_load       = 1'b1;
          w_tmr_val        = c_t_unlock;
        end else if ((int'(r_fail_count) + 1) < MAX_FAILS) begin
          w_state_nxt      = ST_ENTRY;
          w_fail_count_nxt = r_fail_count + c_fcw'(1);
        end else begin
          w_state_nxt      = ST_LOCKOUT;
          w_fail_count_nxt = c_max_fails;
          w_tmr_load       = 1'b1;
          w_tmr_val        = c_t_lockout;
        end
      end

      ST_OPEN: begin
        if (lock_cmd || w_tmr_expired) begin
          w_state_nxt = ST_ENTRY;
        end
      end

      ST_LOCKOUT: begin
        if (w_tmr_expired) begin
          w_state_nxt      = ST_ENTRY;
          w_fail_count_nxt = '0;
        end
      end

      default: begin
        w_state_nxt       = ST_ENTRY;
        w_entry_count_nxt = '0;
        w_mismatch_nxt    = 1'b0;
      end
    endcase
  end

  assign unlocked    = r_unlocked;
  assign alarm       = r_alarm;
  assign err         = r_err;
  assign entry_count = r_entry_count;
  assign fail_count  = r_fail_count;

endmodule
`default_nettype wire
